// File: rtl/vend_dispenser.sv
// Dispense controller: releases items, then tens, then fives, one strobe per ack,
// with an ack timeout that parks the block in FAULT until cleared.
module vend_dispenser #(
    parameter int TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic [2:0] items,
    input  logic [3:0] change,
    input  logic       ack,
    input  logic       clr_fault,
    output logic       item_out,
    output logic       coin10_out,
    output logic       coin5_out,
    output logic       busy,
    output logic       done,
    output logic       load_drop,
    output logic       fault
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ITEM  = 3'd1,
        S_COIN  = 3'd2,
        S_GAP   = 3'd3,
        S_DONE  = 3'd4,
        S_FAULT = 3'd5
    } state_t;

    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    state_t     state_q, state_d;
    logic [2:0] item_cnt_q, item_cnt_d;
    logic [3:0] chg_cnt_q, chg_cnt_d;
    logic [7:0] wait_q, wait_d;
    logic       item_out_q, item_out_d;
    logic       coin10_q, coin10_d;
    logic       coin5_q, coin5_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       load_drop_q, load_drop_d;
    logic       fault_q, fault_d;

    function automatic state_t pick_next(input logic [2:0] n_items, input logic [3:0] n_chg);
        if (n_items != 3'd0) begin
            return S_ITEM;
        end else if (n_chg != 4'd0) begin
            return S_COIN;
        end else begin
            return S_DONE;
        end
    endfunction

    // Next-state, count and wait-counter logic; wait counter is zero outside ITEM/COIN
    always_comb begin
        state_d    = state_q;
        item_cnt_d = item_cnt_q;
        chg_cnt_d  = chg_cnt_q;
        wait_d     = 8'd0;
        case (state_q)
            S_IDLE: begin
                if (load) begin
                    item_cnt_d = items;
                    chg_cnt_d  = change;
                    state_d    = pick_next(items, change);
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ITEM: begin
                // An ack on the expiring cycle still counts as a normal dispense
                if (ack) begin
                    item_cnt_d = item_cnt_q - 3'd1;
                    state_d    = S_GAP;
                end else if (wait_q == WAIT_LAST) begin
                    state_d = S_FAULT;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            S_COIN: begin
                if (ack) begin
                    if (chg_cnt_q >= 4'd2) begin
                        chg_cnt_d = chg_cnt_q - 4'd2;
                    end else begin
                        chg_cnt_d = chg_cnt_q - 4'd1;
                    end
                    state_d = S_GAP;
                end else if (wait_q == WAIT_LAST) begin
                    state_d = S_FAULT;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            S_GAP: begin
                state_d = pick_next(item_cnt_q, chg_cnt_q);
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            S_FAULT: begin
                if (clr_fault) begin
                    item_cnt_d = 3'd0;
                    chg_cnt_d  = 4'd0;
                    state_d    = S_IDLE;
                end else begin
                    state_d = S_FAULT;
                end
            end
            default: begin
                item_cnt_d = 3'd0;
                chg_cnt_d  = 4'd0;
                state_d    = S_IDLE;
            end
        endcase
    end

    // Output decode from the next state so every output leaves a flop
    always_comb begin
        item_out_d  = (state_d == S_ITEM);
        coin10_d    = (state_d == S_COIN) && (chg_cnt_d >= 4'd2);
        coin5_d     = (state_d == S_COIN) && (chg_cnt_d == 4'd1);
        busy_d      = (state_d != S_IDLE);
        done_d      = (state_d == S_DONE);
        fault_d     = (state_d == S_FAULT);
        load_drop_d = load && (state_q != S_IDLE);
    end

    // State, counters and registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            item_cnt_q  <= 3'd0;
            chg_cnt_q   <= 4'd0;
            wait_q      <= 8'd0;
            item_out_q  <= 1'b0;
            coin10_q    <= 1'b0;
            coin5_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            load_drop_q <= 1'b0;
            fault_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            item_cnt_q  <= item_cnt_d;
            chg_cnt_q   <= chg_cnt_d;
            wait_q      <= wait_d;
            item_out_q  <= item_out_d;
            coin10_q    <= coin10_d;
            coin5_q     <= coin5_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            load_drop_q <= load_drop_d;
            fault_q     <= fault_d;
        end
    end

    assign item_out   = item_out_q;
    assign coin10_out = coin10_q;
    assign coin5_out  = coin5_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign load_drop  = load_drop_q;
    assign fault      = fault_q;

endmodule

// File: tb/tb_vend_dispenser.sv
// Self-checking bench for vend_dispenser: table-driven transactions with a strobe
// scoreboard, plus hand-written timeout, ack-race and async-reset sequences.
module tb_vend_dispenser;

    logic       clk = 1'b0;
    logic       reset;
    logic       load;
    logic [2:0] items;
    logic [3:0] change;
    logic       ack;
    logic       clr_fault;
    logic       item_out, coin10_out, coin5_out, busy, done, load_drop, fault;

    int checks = 0;
    int errors = 0;
    int exp_q[$];

    typedef struct {
        logic [2:0] items;
        logic [3:0] change;
        bit         hold;
        int         inj;
        int         n_i;
        int         n_t;
        int         n_f;
        int         done_c;
    } vec_t;

    vec_t vecs[8];

    vend_dispenser #(.TIMEOUT(15)) dut (
        .clk(clk), .reset(reset), .load(load), .items(items), .change(change),
        .ack(ack), .clr_fault(clr_fault), .item_out(item_out), .coin10_out(coin10_out),
        .coin5_out(coin5_out), .busy(busy), .done(done), .load_drop(load_drop), .fault(fault)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int outs();
        return int'({item_out, coin10_out, coin5_out, busy, done, load_drop, fault});
    endfunction

    function automatic int code();
        if (item_out) return 1;
        else if (coin10_out) return 2;
        else if (coin5_out) return 3;
        else return 0;
    endfunction

    task automatic run_vec(input vec_t v, input int idx);
        int  c;
        int  prev;
        int  cur;
        bit  seen_done;
        for (int i = 0; i < v.n_i; i++) exp_q.push_back(1);
        for (int i = 0; i < v.n_t; i++) exp_q.push_back(2);
        for (int i = 0; i < v.n_f; i++) exp_q.push_back(3);
        ack    = v.hold;
        load   = 1'b1;
        items  = v.items;
        change = v.change;
        step();
        load   = 1'b0;
        items  = 3'd0;
        change = 4'd0;
        c = 1;
        prev = 0;
        seen_done = 1'b0;
        while (!seen_done && c <= 60) begin
            cur = code();
            chk($sformatf("v%0d_c%0d_onehot", idx, c),
                int'($countones({item_out, coin10_out, coin5_out}) <= 1), 1);
            if (prev != 0) chk($sformatf("v%0d_c%0d_gap", idx, c), cur, 0);
            if (cur != 0 && prev == 0) begin
                if (exp_q.size() == 0) chk($sformatf("v%0d_c%0d_extra_strobe", idx, c), cur, 0);
                else chk($sformatf("v%0d_c%0d_strobe_order", idx, c), cur, exp_q.pop_front());
            end
            chk($sformatf("v%0d_c%0d_load_drop", idx, c), int'(load_drop),
                int'(v.inj != 0 && c == v.inj + 1));
            chk($sformatf("v%0d_c%0d_busy", idx, c), int'(busy), 1);
            chk($sformatf("v%0d_c%0d_fault", idx, c), int'(fault), 0);
            if (done) begin
                chk($sformatf("v%0d_done_cycle", idx), c, v.done_c);
                seen_done = 1'b1;
            end
            if (!v.hold) ack = (cur != 0);
            if (c == v.inj) begin
                load   = 1'b1;
                items  = 3'd3;
                change = 4'd9;
            end else begin
                load = 1'b0;
            end
            prev = cur;
            step();
            c++;
        end
        load = 1'b0;
        if (!seen_done) chk($sformatf("v%0d_done_timeout", idx), 0, 1);
        chk($sformatf("v%0d_queue_left", idx), exp_q.size(), 0);
        exp_q.delete();
        chk($sformatf("v%0d_post_idle", idx), outs(), 0);
        ack = 1'b0;
        step();
    endtask

    initial begin
        int cnt;
        vecs[0] = '{3'd2, 4'd5,  1'b0, 0, 2, 2, 1, 11};
        vecs[1] = '{3'd0, 4'd0,  1'b0, 0, 0, 0, 0, 1};
        vecs[2] = '{3'd1, 4'd3,  1'b1, 0, 1, 1, 1, 7};
        vecs[3] = '{3'd0, 4'd1,  1'b1, 0, 0, 0, 1, 3};
        vecs[4] = '{3'd7, 4'd0,  1'b0, 0, 7, 0, 0, 15};
        vecs[5] = '{3'd0, 4'd15, 1'b1, 0, 0, 7, 1, 17};
        vecs[6] = '{3'd3, 4'd4,  1'b0, 0, 3, 2, 0, 11};
        vecs[7] = '{3'd0, 4'd4,  1'b0, 1, 0, 2, 0, 5};

        reset = 1'b1; load = 1'b0; items = 3'd0; change = 4'd0; ack = 1'b0; clr_fault = 1'b0;
        #1 reset = 1'b0;
        #1 chk("reset_outs", outs(), 0);
        step();
        step();
        reset = 1'b1;
        step();
        chk("after_reset_outs", outs(), 0);

        for (int i = 0; i < 8; i++) run_vec(vecs[i], i);

        // Ack never arrives: item strobe held exactly TIMEOUT cycles, then FAULT
        ack = 1'b0; load = 1'b1; items = 3'd1; change = 4'd1;
        step();
        load = 1'b0; items = 3'd0; change = 4'd0;
        cnt = 0;
        while (item_out && cnt < 40) begin
            cnt++;
            step();
        end
        chk("timeout_len", cnt, 15);
        chk("timeout_fault", int'(fault), 1);
        chk("timeout_busy", int'(busy), 1);
        chk("timeout_strobes", code(), 0);
        ack = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("fault_hold_%0d", i), outs(), 7'b0001001);
        end
        ack = 1'b0;
        load = 1'b1; items = 3'd2; change = 4'd2;
        step();
        load = 1'b0;
        chk("fault_load_drop", outs(), 7'b0001011);
        step();
        chk("fault_load_drop_end", outs(), 7'b0001001);
        clr_fault = 1'b1;
        step();
        clr_fault = 1'b0;
        chk("clr_fault_outs", outs(), 0);
        for (int i = 0; i < 4; i++) begin
            step();
            chk($sformatf("idle_after_clr_%0d", i), outs(), 0);
        end

        // Ack on the very cycle the wait counter expires wins over the fault
        load = 1'b1; items = 3'd1; change = 4'd0;
        step();
        load = 1'b0; items = 3'd0;
        for (int c = 1; c <= 15; c++) begin
            chk($sformatf("race_item_c%0d", c), int'(item_out), 1);
            if (c == 15) ack = 1'b1;
            step();
        end
        ack = 1'b0;
        chk("race_gap", outs(), 7'b0001000);
        step();
        chk("race_done", outs(), 7'b0001100);
        step();
        chk("race_idle", outs(), 0);

        // Async reset while a ten-coin strobe is up
        load = 1'b1; items = 3'd0; change = 4'd6;
        step();
        load = 1'b0; change = 4'd0;
        chk("rst_pre_coin10", outs(), 7'b0101000);
        #2 reset = 1'b0;
        #1 chk("rst_async_outs", outs(), 0);
        #2 reset = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            chk($sformatf("rst_release_%0d", i), outs(), 0);
        end
        run_vec('{3'd1, 4'd0, 1'b0, 0, 1, 0, 0, 3}, 8);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
